// File: rtl/bcd_calc_pkg.sv
// Shared types, keypad codes and the single-digit BCD add/subtract helper
// used by the keypad calculator.
package bcd_calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPA,
        OPB,
        CALC,
        SHOW
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hE;

    // One BCD digit of add (carry in/out) or subtract (borrow in/out).
    // Returns {carry_or_borrow, digit}.
    function automatic logic [4:0] bcd_digit_addsub(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin,
        input logic       sub
    );
        logic [4:0] t;
        logic [4:0] r;
        if (sub) begin
            t = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
            if (t[4]) begin
                r = {1'b1, t[3:0] + 4'd10};
            end else begin
                r = {1'b0, t[3:0]};
            end
        end else begin
            t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
            if (t > 5'd9) begin
                r = {1'b1, t[3:0] + 4'd6};
            end else begin
                r = {1'b0, t[3:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: emits a one-cycle press pulse with the captured code once
// the key has been held for DEBOUNCE_CYCLES clocks, then re-arms only after
// the key has been released for DEBOUNCE_CYCLES clocks.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pressed,
    input  logic [3:0] key_code,
    output logic       press,
    output logic [3:0] code
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          wait_release;

    // Count consecutive samples at the level being waited for; any
    // opposite-level sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            wait_release <= 1'b0;
            press        <= 1'b0;
            code         <= 4'h0;
        end else begin
            press <= 1'b0;
            if (!wait_release) begin
                if (key_pressed) begin
                    if (cnt == LAST) begin
                        press        <= 1'b1;
                        code         <= key_code;
                        wait_release <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end else begin
                if (!key_pressed) begin
                    if (cnt == LAST) begin
                        wait_release <= 1'b0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_keypad_calc.sv
// Keypad BCD calculator: collects two DIGITS-digit operands from debounced
// key events and adds (or subtracts) them one digit per clock.
// Optional feature macro: BCD_CALC_SUB_EN enables the B (subtract) key and
// the neg output; without it B is ignored and neg stays 0.
module bcd_keypad_calc
    import bcd_calc_pkg::*;
#(
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_pressed,
    input  logic [3:0]              key_code,
    output logic [4*(DIGITS+1)-1:0] disp_bcd,
    output logic                    neg,
    output logic                    busy,
    output logic                    done,
    output logic                    entry_err
);

`ifdef BCD_CALC_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    localparam int OPW = 4 * DIGITS;
    localparam int RW  = 4 * (DIGITS + 1);
    localparam int CW  = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL     = CW'(DIGITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS);

    state_t state, next_state;

    logic           key_evt;
    logic [3:0]     key_val;
    logic [OPW-1:0] op_a, op_b;
    logic [CW-1:0]  cnt_a, cnt_b;
    logic [RW-1:0]  result;
    logic [CW-1:0]  calc_idx;
    logic [CW-1:0]  dig_sel;
    logic           is_sub, swap, carry, neg_q;

    logic is_digit, is_op, is_clr, is_eq, res_msd_zero, a_lt_b;
    logic clear_all, a_new, a_shift, b_shift, to_opb, load_res;
    logic set_err, calc_start, calc_last;
    logic [OPW-1:0] a_shifted, b_shifted;
    logic [3:0]     a_dig, b_dig, x_dig, y_dig;
    logic [4:0]     step;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_pressed(key_pressed),
        .key_code   (key_code),
        .press      (key_evt),
        .code       (key_val)
    );

    // Key classification, operand shift-in values and the digit-serial datapath slice.
    always_comb begin
        is_digit     = (key_val <= 4'd9);
        is_op        = (key_val == KEY_ADD) || (SUB_EN && (key_val == KEY_SUB));
        is_clr       = (key_val == KEY_CLR);
        is_eq        = (key_val == KEY_EQ);
        res_msd_zero = (result[RW-1 -: 4] == 4'h0);
        a_lt_b       = (op_a < op_b);
        a_shifted    = (op_a << 4) | OPW'(key_val);
        b_shifted    = (op_b << 4) | OPW'(key_val);
        dig_sel      = (calc_idx == '0) ? '0 : (calc_idx - 1'b1);
        a_dig        = op_a[dig_sel*4 +: 4];
        b_dig        = op_b[dig_sel*4 +: 4];
        x_dig        = swap ? b_dig : a_dig;
        y_dig        = swap ? a_dig : b_dig;
        step         = bcd_digit_addsub(x_dig, y_dig, carry, is_sub);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and datapath strobes; key events are only acted on outside CALC.
    always_comb begin
        next_state = state;
        clear_all  = 1'b0;
        a_new      = 1'b0;
        a_shift    = 1'b0;
        b_shift    = 1'b0;
        to_opb     = 1'b0;
        load_res   = 1'b0;
        set_err    = 1'b0;
        calc_start = 1'b0;
        calc_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_evt) begin
                    if (is_digit) begin
                        a_new      = 1'b1;
                        next_state = OPA;
                    end else if (is_clr) begin
                        clear_all = 1'b1;
                    end
                end
            end
            OPA: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (cnt_a == FULL) set_err = 1'b1;
                        else               a_shift = 1'b1;
                    end else if (is_op) begin
                        to_opb     = 1'b1;
                        next_state = OPB;
                    end else if (is_clr) begin
                        clear_all  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            OPB: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (cnt_b == FULL) set_err = 1'b1;
                        else               b_shift = 1'b1;
                    end else if (is_eq) begin
                        calc_start = 1'b1;
                        next_state = CALC;
                    end else if (is_clr) begin
                        clear_all  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            CALC: begin
                if (calc_idx == LAST_IDX) begin
                    calc_last  = 1'b1;
                    next_state = SHOW;
                end
            end
            SHOW: begin
                if (key_evt) begin
                    if (is_digit) begin
                        a_new      = 1'b1;
                        next_state = OPA;
                    end else if (is_op) begin
                        if (res_msd_zero && !neg_q) begin
                            to_opb     = 1'b1;
                            load_res   = 1'b1;
                            next_state = OPB;
                        end
                    end else if (is_clr) begin
                        clear_all  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand entry, error flag and the compare-then-digit-serial calculation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            result    <= '0;
            calc_idx  <= '0;
            is_sub    <= 1'b0;
            swap      <= 1'b0;
            carry     <= 1'b0;
            neg_q     <= 1'b0;
            entry_err <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= calc_last;
            if (clear_all) begin
                op_a      <= '0;
                op_b      <= '0;
                cnt_a     <= '0;
                cnt_b     <= '0;
                result    <= '0;
                neg_q     <= 1'b0;
                entry_err <= 1'b0;
            end else if (a_new) begin
                op_a      <= OPW'(key_val);
                cnt_a     <= CW'(1);
                result    <= '0;
                neg_q     <= 1'b0;
                entry_err <= 1'b0;
            end else if (a_shift) begin
                op_a  <= a_shifted;
                cnt_a <= cnt_a + 1'b1;
            end else if (b_shift) begin
                op_b  <= b_shifted;
                cnt_b <= cnt_b + 1'b1;
            end else if (set_err) begin
                entry_err <= 1'b1;
            end else if (to_opb) begin
                op_b      <= '0;
                cnt_b     <= '0;
                entry_err <= 1'b0;
                is_sub    <= (key_val == KEY_SUB);
                if (load_res) begin
                    op_a  <= result[OPW-1:0];
                    cnt_a <= FULL;
                end
            end else if (calc_start) begin
                calc_idx <= '0;
            end else if (state == CALC) begin
                calc_idx <= calc_idx + 1'b1;
                if (calc_idx == '0) begin
                    swap   <= SUB_EN && is_sub && a_lt_b;
                    neg_q  <= SUB_EN && is_sub && a_lt_b;
                    carry  <= 1'b0;
                    result <= '0;
                end else begin
                    result[dig_sel*4 +: 4] <= step[3:0];
                    carry                  <= step[4];
                    if (calc_idx == LAST_IDX) begin
                        result[RW-1 -: 4] <= is_sub ? 4'h0 : {3'b000, step[4]};
                    end
                end
            end
        end
    end

    // Display source follows the state; CALC keeps showing operand B.
    always_comb begin
        disp_bcd = '0;
        unique case (state)
            IDLE, OPA: disp_bcd = {4'h0, op_a};
            OPB, CALC: disp_bcd = {4'h0, op_b};
            SHOW:      disp_bcd = result;
            default:   disp_bcd = '0;
        endcase
    end

    assign busy = (state == CALC);
    assign neg  = SUB_EN ? neg_q : 1'b0;

endmodule

// File: tb/tb_bcd_keypad_calc.sv
// Directed, table-driven bench for bcd_keypad_calc (DIGITS=3, short debounce).
// Builds either way; the subtraction vectors follow BCD_CALC_SUB_EN.
module tb_bcd_keypad_calc;
    import bcd_calc_pkg::*;

    localparam int DIGITS = 3;
    localparam int DB     = 4;
    localparam int DW     = 4 * (DIGITS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_pressed = 1'b0;
    logic [3:0]    key_code = 4'h0;
    logic [DW-1:0] disp_bcd;
    logic          neg, busy, done, entry_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]    code;
        logic [DW-1:0] disp;
        logic          err;
        logic          neg;
        bit            timed;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bcd_keypad_calc #(
        .DIGITS         (DIGITS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_pressed(key_pressed),
        .key_code   (key_code),
        .disp_bcd   (disp_bcd),
        .neg        (neg),
        .busy       (busy),
        .done       (done),
        .entry_err  (entry_err)
    );

    function automatic void addVec(input logic [3:0] code, input logic [DW-1:0] disp,
                                   input logic err, input logic n, input bit timed);
        vec_t v;
        v.code  = code;
        v.disp  = disp;
        v.err   = err;
        v.neg   = n;
        v.timed = timed;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full press and release, long enough for both debounce windows.
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_code    = code;
        key_pressed = 1'b1;
        repeat (DB + 1) @(negedge clk);
        key_pressed = 1'b0;
        repeat (DB + 1) @(negedge clk);
    endtask

    // Equals press with cycle-accurate observation of busy and done.
    task automatic applyTimedEquals(input logic [3:0] code);
        int busy_first = -1;
        int busy_cnt   = 0;
        int done_at    = -1;
        int done_cnt   = 0;
        @(negedge clk);
        key_code    = code;
        key_pressed = 1'b1;
        for (int i = 1; i <= 3 * DB + DIGITS + 8; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = i;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i == DB + 1) key_pressed = 1'b0;
        end
        checkOutput("busy_start", 32'(busy_first), 32'(DB + 1));
        checkOutput("busy_len",   32'(busy_cnt),   32'(DIGITS + 1));
        checkOutput("done_time",  32'(done_at),    32'(DB + DIGITS + 2));
        checkOutput("done_pulses", 32'(done_cnt),  32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;

        // Test 1: 534 + 961
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(4'h3, 16'h0053, 1'b0, 1'b0, 1'b0);
        addVec(4'h4, 16'h0534, 1'b0, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0009, 1'b0, 1'b0, 1'b0);
        addVec(4'h6, 16'h0096, 1'b0, 1'b0, 1'b0);
        addVec(4'h1, 16'h0961, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h1495, 1'b0, 1'b0, 1'b1);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
        // Test 2: 999 + 999, operator with MSD=1 ignored, then chaining
        addVec(4'h9, 16'h0009, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0099, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0999, 1'b0, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0009, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0099, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0999, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h1998, 1'b0, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h1998, 1'b0, 1'b0, 1'b0);
        addVec(4'h7, 16'h0007, 1'b0, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h2, 16'h0002, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0009, 1'b0, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0014, 1'b0, 1'b0, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
        // Test 5: overflowing entry, E outside OPB, clearing of entry_err
        addVec(4'h1, 16'h0001, 1'b0, 1'b0, 1'b0);
        addVec(4'h2, 16'h0012, 1'b0, 1'b0, 1'b0);
        addVec(4'h3, 16'h0123, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0123, 1'b0, 1'b0, 1'b0);
        addVec(4'h4, 16'h0123, 1'b1, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h1, 16'h0001, 1'b0, 1'b0, 1'b0);
        addVec(4'h2, 16'h0012, 1'b0, 1'b0, 1'b0);
        addVec(4'h3, 16'h0123, 1'b0, 1'b0, 1'b0);
        addVec(4'h4, 16'h0123, 1'b1, 1'b0, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef BCD_CALC_SUB_EN
        // Test 3: 534 - 961, 961 - 534, 5 - 5, negative result blocks chaining
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(4'h3, 16'h0053, 1'b0, 1'b0, 1'b0);
        addVec(4'h4, 16'h0534, 1'b0, 1'b0, 1'b0);
        addVec(KEY_SUB, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0009, 1'b0, 1'b0, 1'b0);
        addVec(4'h6, 16'h0096, 1'b0, 1'b0, 1'b0);
        addVec(4'h1, 16'h0961, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0427, 1'b0, 1'b1, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h9, 16'h0009, 1'b0, 1'b0, 1'b0);
        addVec(4'h6, 16'h0096, 1'b0, 1'b0, 1'b0);
        addVec(4'h1, 16'h0961, 1'b0, 1'b0, 1'b0);
        addVec(KEY_SUB, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(4'h3, 16'h0053, 1'b0, 1'b0, 1'b0);
        addVec(4'h4, 16'h0534, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0427, 1'b0, 1'b0, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(KEY_SUB, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h1, 16'h0001, 1'b0, 1'b0, 1'b0);
        addVec(KEY_SUB, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h2, 16'h0002, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0001, 1'b0, 1'b1, 1'b0);
        addVec(KEY_ADD, 16'h0001, 1'b0, 1'b1, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
`else
        // B is not an operator in this build: stays in operand A entry
        addVec(4'h5, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(KEY_SUB, 16'h0005, 1'b0, 1'b0, 1'b0);
        addVec(KEY_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        addVec(4'h3, 16'h0003, 1'b0, 1'b0, 1'b0);
        addVec(KEY_EQ, 16'h0008, 1'b0, 1'b0, 1'b0);
        addVec(KEY_CLR, 16'h0000, 1'b0, 1'b0, 1'b0);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_disp", 32'(disp_bcd), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_err",  32'(entry_err), 32'h0);
        checkOutput("reset_neg",  32'(neg), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 4: press one clock too short
        key_code    = 4'h5;
        key_pressed = 1'b1;
        repeat (DB - 1) @(negedge clk);
        key_pressed = 1'b0;
        repeat (DB + 2) @(negedge clk);
        checkOutput("glitch_disp", 32'(disp_bcd), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].timed) applyTimedEquals(vecs[i].code);
            else               applyStimulus(vecs[i].code);
            checkOutput($sformatf("vec%0d_disp", i), 32'(disp_bcd),  32'(vecs[i].disp));
            checkOutput($sformatf("vec%0d_err", i),  32'(entry_err), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d_neg", i),  32'(neg),       32'(vecs[i].neg));
        end

        // Test 6: asynchronous reset in the middle of CALC
        applyStimulus(4'h1);
        applyStimulus(KEY_ADD);
        applyStimulus(4'h2);
        @(negedge clk);
        key_code    = KEY_EQ;
        key_pressed = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 * DB && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        checkOutput("midcalc_busy_seen", 32'(seen), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc_rst_busy", 32'(busy), 32'h0);
        checkOutput("midcalc_rst_done", 32'(done), 32'h0);
        checkOutput("midcalc_rst_disp", 32'(disp_bcd), 32'h0);
        key_pressed = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(4'h7);
        applyStimulus(KEY_ADD);
        applyStimulus(4'h2);
        applyStimulus(KEY_EQ);
        checkOutput("after_rst_disp", 32'(disp_bcd), 32'h0009);
        checkOutput("after_rst_neg",  32'(neg), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_keypad_calc.md
Name: bcd_keypad_calc

Overview:
- Parametrised successor to the fixed 3-digit keypad adder.
- Accepts debounced keypad codes, builds two BCD operands of DIGITS digits each, and computes A+B (or A−B with SUB_EN) with a serial digit-per-cycle BCD datapath.
- Drives a BCD display word.
- Sits between the keypad scanner and the 7-segment display driver.

Parameters:
- DIGITS, 3: BCD digits per operand (1..8).
- DEBOUNCE_CYCLES, 16: consecutive stable clocks needed to accept a press or a release (≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_pressed  in  1  raw level from the scanner; high while any key is down
- key_code  in  4  scanner code; 0–9 digit, A add, B sub, C clear, E equals; others ignored
- disp_bcd  out  4*(DIGITS+1)  BCD display word, MSD first
- neg  out  1  result is negative (SUB_EN only)
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse when a result becomes valid
- entry_err  out  1  sticky; set when a digit is dropped because the operand is full; cleared by C or a new operand

Behaviour:
- Reset (async, rst_n=0): state IDLE. All registers cleared: disp_bcd=0, neg=0, busy=0, done=0, entry_err=0. Debounce counter cleared.
- Debounce:
  - A press event is generated once key_pressed has been high for DEBOUNCE_CYCLES consecutive clocks.
  - key_code is captured in that same cycle.
  - No new event until key_pressed has been low for DEBOUNCE_CYCLES consecutive clocks.
  - Shorter glitches produce nothing.
- FSM states: IDLE, OPA, OPB, CALC, SHOW.
- IDLE/OPA, digit key:
  - opA = {opA shifted left one digit, digit}; go to OPA.
  - If DIGITS digits are already entered, the digit is dropped and entry_err is set.
- OPA, A key (or B with SUB_EN): latch the operation, clear opB, go to OPB. Operator keys in IDLE are ignored.
- OPB, digit key: same shift-in and drop rules as OPA. E key: go to CALC.
- E outside OPB: ignored.
- C in any state except CALC: opA, opB, result, neg and entry_err cleared; go to IDLE.
- CALC:
  - Takes exactly DIGITS+1 cycles.
  - Cycle 0: compares A and B (BCD compare is monotonic) and selects operand order.
  - Cycles 1..DIGITS: LSD-first digit add/sub with carry/borrow and decimal correction.
  - Final carry goes to result digit DIGITS.
  - busy is high for all DIGITS+1 cycles. All key events are ignored and discarded.
- CALC → SHOW: done pulses in the first SHOW cycle.
- SHOW, digit key: result is cleared and a new A starts with that digit (OPA).
- SHOW, operator key:
  - If the result MSD is 0 and neg=0, opA = low DIGITS result digits and go to OPB.
  - Otherwise the key is ignored.
- disp_bcd by state: IDLE/OPA show opA zero-extended; OPB shows opB; CALC holds the previous value; SHOW shows the result.
- Subtraction (SUB_EN):
  - If A≥B, result = A−B and neg=0.
  - Otherwise result = B−A and neg=1.
  - Result MSD is always 0.
  - A−A gives 0 with neg=0.
- Simultaneous events: key_pressed edges during the debounce window only restart the count. Reset overrides everything, including mid-CALC.

Optional Feature:
- Macro: BCD_CALC_SUB_EN.
- Defined: B key selects subtraction, and the neg port logic is active.
- Undefined: B key is ignored, neg is tied to 0, and the compare cycle still exists so latency stays DIGITS+1.

Decomposition:
- Package bcd_calc_pkg:
  - state_t enum.
  - Key-code constants KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_CLR=4'hC, KEY_EQ=4'hE.
  - Function bcd_digit_addsub(a, b, cin, sub) returning {cout, digit}.
- Sub-module key_debounce (params DEBOUNCE_CYCLES): produces a press pulse and the captured code.

Test Plan:
1. DIGITS=3, keys 5,3,4,A,9,6,1,E → done pulses DIGITS+1+1 cycles after E is accepted; disp_bcd=16'h1495, neg=0.
2. 9,9,9,A,9,9,9,E → disp_bcd=16'h1998. Then A → opA not loaded (MSD≠0), state stays SHOW.
3. SUB_EN: 5,3,4,B,9,6,1,E → disp_bcd=16'h0427, neg=1. Also 961−534 → 16'h0427, neg=0.
4. key_pressed high for DEBOUNCE_CYCLES−1 clocks, then low → no digit accepted; disp_bcd stays 0.
5. Keys 1,2,3,4 → 4 dropped, entry_err=1, disp shows 0123. Then C → disp_bcd=0, entry_err=0, IDLE.
6. rst_n low for 1 ns mid-CALC → busy, done, disp_bcd immediately 0. After release, 7,A,2,E → 16'h0009.
